stream_demux: RTL and testbench

- 1-to-N valid/ready stream demultiplexer; the sequential counterpart of the team's 2:1 combinational mux.
- Routes each packet from one source stream to the destination selected by s_sel.
- The destination is locked for the whole packet.
- Output is a single registered stage, giving full throughput and 1-cycle latency.
- Sits between a packet producer and N consumer channels; out-of-range selects are dropped and flagged.

---
 rtl/stream_pkg.sv | 26 ++
 rtl/stream_demux_if.sv | 34 +++
 rtl/stream_demux.sv | 121 ++++++++++++
 tb/tb_stream_demux.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream demultiplexer.
// Holds the FSM state encoding and the select-width calculation.
package stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    DROP = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((64'd1 << r) < 64'(n)) r = r + 1;
    end
    return r;
  endfunction

  // Select width never drops below one bit.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Source stream plus N destination channels of the stream demultiplexer.
// The slave modport is the demux view; master is the producer/consumer view.
interface stream_demux_if
  import stream_pkg::*;
#(
  parameter int N_OUT  = 3,
  parameter int DATA_W = 8
);

  localparam int SEL_W = sel_width(N_OUT);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic [SEL_W-1:0]  s_sel;

  logic [N_OUT-1:0]  m_valid;
  logic [N_OUT-1:0]  m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              err_sel;

  modport slave (
    input  s_valid, s_data, s_last, s_sel, m_ready,
    output s_ready, m_valid, m_data, m_last, err_sel
  );

  modport master (
    output s_valid, s_data, s_last, s_sel, m_ready,
    input  s_ready, m_valid, m_data, m_last, err_sel
  );

endinterface

// File: rtl/stream_demux.sv
// 1-to-N packet demux with destination locked per packet; one registered stage, 1-cycle latency.
// Source stalls only when the held beat's own channel is not ready; bad selects are drained and flagged.
module stream_demux
  import stream_pkg::*;
#(
  parameter int N_OUT  = 3,
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  stream_demux_if.slave bus
);

  localparam int SEL_W = sel_width(N_OUT);

  state_t            state, state_nxt;
  logic              o_vld, o_vld_nxt;
  logic [SEL_W-1:0]  o_dst, o_dst_nxt;
  logic [DATA_W-1:0] o_data, o_data_nxt;
  logic              o_last, o_last_nxt;
  logic              err, err_nxt;

  logic              dst_rdy;
  logic              adv;
  logic              sel_ok;
  logic              s_rdy;
  logic              load;
  logic              first;

  // Ready of the channel currently addressed; all other readies are ignored.
  always_comb begin
    dst_rdy = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if (o_dst == SEL_W'(i)) dst_rdy = bus.m_ready[i];
    end
  end

  assign adv    = !o_vld || dst_rdy;
  assign sel_ok = 32'(bus.s_sel) < $unsigned(N_OUT);

  // s_ready depends only on state and the register, never on s_sel/s_data.
  always_comb begin
    state_nxt = state;
    s_rdy     = adv;
    load      = 1'b0;
    first     = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.s_valid && s_rdy) begin
          if (sel_ok) begin
            load      = 1'b1;
            first     = 1'b1;
            state_nxt = bus.s_last ? IDLE : LOCK;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = bus.s_last ? IDLE : DROP;
          end
        end
      end
      LOCK: begin
        if (bus.s_valid && s_rdy) begin
          load = 1'b1;
          if (bus.s_last) state_nxt = IDLE;
        end
      end
      DROP: begin
        s_rdy = 1'b1;
        if (bus.s_valid && bus.s_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A load wins over a drain so back-to-back beats keep o_vld high.
  always_comb begin
    o_vld_nxt  = o_vld;
    o_dst_nxt  = o_dst;
    o_data_nxt = o_data;
    o_last_nxt = o_last;
    if (load) begin
      o_vld_nxt  = 1'b1;
      o_data_nxt = bus.s_data;
      o_last_nxt = bus.s_last;
      if (first) o_dst_nxt = bus.s_sel;
    end else if (o_vld && dst_rdy) begin
      o_vld_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      o_vld  <= 1'b0;
      o_dst  <= '0;
      o_data <= '0;
      o_last <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_vld  <= o_vld_nxt;
      o_dst  <= o_dst_nxt;
      o_data <= o_data_nxt;
      o_last <= o_last_nxt;
      err    <= err_nxt;
    end
  end

  always_comb begin
    bus.m_valid = '0;
    for (int i = 0; i < N_OUT; i++) begin
      bus.m_valid[i] = o_vld && (o_dst == SEL_W'(i));
    end
  end

  assign bus.s_ready = s_rdy;
  assign bus.m_data  = o_data;
  assign bus.m_last  = o_last;
  assign bus.err_sel = err;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux (N_OUT=3, DATA_W=8): reset, routing, stalls, switching, bad selects.
module tb_stream_demux;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  stream_demux_if #(.N_OUT(3), .DATA_W(8)) bus ();

  stream_demux #(.N_OUT(3), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] sel, input logic last);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.s_sel   = sel;
    bus.s_last  = last;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    bus.m_ready = 3'b111;
    #1;
    check("rst_m_valid", 32'(bus.m_valid), 32'h0);
    check("rst_s_ready", 32'(bus.s_ready), 32'h1);
    check("rst_err_sel", 32'(bus.err_sel), 32'h0);
    check("rst_m_data",  32'(bus.m_data),  32'h0);
    check("rst_m_last",  32'(bus.m_last),  32'h0);
    #22 rst_n = 1'b1;

    // Start a packet, then reset in the middle of it
    step();
    drive(1'b1, 8'h55, 2'd2, 1'b0);
    step();
    check("pre_rst_m_valid", 32'(bus.m_valid), 32'h4);
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_m_valid", 32'(bus.m_valid), 32'h0);
    check("midrst_err_sel", 32'(bus.err_sel), 32'h0);
    check("midrst_s_ready", 32'(bus.s_ready), 32'h1);
    #3 rst_n = 1'b1;
    drive(1'b1, 8'h66, 2'd1, 1'b1);
    step();
    check("postrst_m_valid", 32'(bus.m_valid), 32'h2);
    check("postrst_m_data",  32'(bus.m_data),  32'h66);
    check("postrst_m_last",  32'(bus.m_last),  32'h1);
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    step();
    check("postrst_drain", 32'(bus.m_valid), 32'h0);

    // Three-beat packet to ch2; s_sel changes mid-packet without effect
    drive(1'b1, 8'hA1, 2'd2, 1'b0);
    step();
    check("pkt_b1_valid", 32'(bus.m_valid), 32'h4);
    check("pkt_b1_data",  32'(bus.m_data),  32'hA1);
    check("pkt_b1_last",  32'(bus.m_last),  32'h0);
    drive(1'b1, 8'hA2, 2'd0, 1'b0);
    step();
    check("pkt_b2_valid", 32'(bus.m_valid), 32'h4);
    check("pkt_b2_data",  32'(bus.m_data),  32'hA2);
    check("pkt_b2_last",  32'(bus.m_last),  32'h0);
    drive(1'b1, 8'hA3, 2'd0, 1'b1);
    step();
    check("pkt_b3_valid", 32'(bus.m_valid), 32'h4);
    check("pkt_b3_data",  32'(bus.m_data),  32'hA3);
    check("pkt_b3_last",  32'(bus.m_last),  32'h1);
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    step();
    check("pkt_drain", 32'(bus.m_valid), 32'h0);

    // Backpressure on ch0
    bus.m_ready = 3'b110;
    drive(1'b1, 8'hB1, 2'd0, 1'b0);
    #1;
    check("bp_s_ready_empty", 32'(bus.s_ready), 32'h1);
    step();
    check("bp_valid", 32'(bus.m_valid), 32'h1);
    check("bp_data",  32'(bus.m_data),  32'hB1);
    check("bp_s_ready_full", 32'(bus.s_ready), 32'h0);
    drive(1'b1, 8'hB2, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_valid", 32'(bus.m_valid), 32'h1);
      check("bp_hold_data",  32'(bus.m_data),  32'hB1);
      check("bp_hold_ready", 32'(bus.s_ready), 32'h0);
    end
    bus.m_ready = 3'b111;
    #1;
    check("bp_release_ready", 32'(bus.s_ready), 32'h1);
    step();
    check("bp_b2_valid", 32'(bus.m_valid), 32'h1);
    check("bp_b2_data",  32'(bus.m_data),  32'hB2);
    drive(1'b1, 8'hB3, 2'd0, 1'b1);
    step();
    check("bp_b3_data", 32'(bus.m_data), 32'hB3);
    check("bp_b3_last", 32'(bus.m_last), 32'h1);
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    step();
    check("bp_drain", 32'(bus.m_valid), 32'h0);

    // Back-to-back single-beat packets to different channels
    drive(1'b1, 8'h11, 2'd1, 1'b1);
    step();
    check("b2b_ch1_valid", 32'(bus.m_valid), 32'h2);
    check("b2b_ch1_data",  32'(bus.m_data),  32'h11);
    drive(1'b1, 8'h22, 2'd2, 1'b1);
    step();
    check("b2b_ch2_valid", 32'(bus.m_valid), 32'h4);
    check("b2b_ch2_data",  32'(bus.m_data),  32'h22);
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    step();
    check("b2b_drain", 32'(bus.m_valid), 32'h0);

    // Out-of-range select: drained, flagged once, then normal traffic resumes
    drive(1'b1, 8'hEE, 2'd3, 1'b0);
    #1;
    check("oor_b1_ready", 32'(bus.s_ready), 32'h1);
    step();
    check("oor_err_pulse", 32'(bus.err_sel), 32'h1);
    check("oor_b1_valid",  32'(bus.m_valid), 32'h0);
    drive(1'b1, 8'hEF, 2'd3, 1'b1);
    #1;
    check("oor_b2_ready", 32'(bus.s_ready), 32'h1);
    step();
    check("oor_err_once", 32'(bus.err_sel), 32'h0);
    check("oor_b2_valid", 32'(bus.m_valid), 32'h0);
    drive(1'b1, 8'h77, 2'd0, 1'b1);
    step();
    check("oor_next_valid", 32'(bus.m_valid), 32'h1);
    check("oor_next_data",  32'(bus.m_data),  32'h77);
    check("oor_next_err",   32'(bus.err_sel), 32'h0);
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    step();
    check("oor_drain", 32'(bus.m_valid), 32'h0);

    // Ch1 streaming while the other readies toggle randomly
    drive(1'b1, 8'hC0, 2'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("ign_valid", 32'(bus.m_valid), 32'h2);
      check("ign_data",  32'(bus.m_data),  32'(8'hC0 + i));
      bus.m_ready = {1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1))};
      if (i < 7) drive(1'b1, 8'(8'hC1 + i), 2'($urandom_range(0, 3)), (i == 6));
      else       drive(1'b0, 8'h00, 2'd0, 1'b0);
      #1;
      check("ign_s_ready", 32'(bus.s_ready), 32'h1);
    end
    step();
    check("ign_drain", 32'(bus.m_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
